pipeline_ctrl: RTL and testbench

- Central stall/flush scheduler for the five-stage pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers.
- Merges stall requests from the ID, EX and MEM stages and drives a per-stage stall vector, so an older stage keeps advancing while a younger stalled stage inserts a bubble.
- Sequences multi-cycle EX operations (divide) with an internal down-counter.
- Converts exception requests into a one-cycle pipeline flush plus a redirect PC, and keeps a saturating stall-cycle counter for debug.

---
 rtl/pipeline_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: merges stage stall requests,
// sequences multi-cycle EX operations, and turns exceptions into flush + redirect.
module pipeline_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall_req_id,
  input  logic                stall_req_mem,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_len,
  input  logic                exc_valid,
  input  logic [ADDR_W-1:0]   exc_vector,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                mc_busy,
  output logic                mc_done,
  output logic [PERF_W-1:0]   stall_cycles
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MC   = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [MC_CNT_W-1:0] cnt_r;
  logic [MC_CNT_W-1:0] cnt_next_s;
  logic [ADDR_W-1:0]   new_pc_r;
  logic [PERF_W-1:0]   stall_cycles_r;

  logic                len_multi_s;
  logic                mc_busy_s;
  logic                mc_done_s;
  logic                ex_req_s;
  logic                flush_s;
  logic [5:0]          stall_s;
  logic [ADDR_W-1:0]   new_pc_s;

  assign len_multi_s = (mc_len >= MC_CNT_W'(2));

  // State and multi-cycle counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {MC_CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic: exceptions abort any op; MEM waits freeze the countdown
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (exc_valid) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = {MC_CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mc_start && len_multi_s) begin
            state_next_s = ST_MC;
            cnt_next_s   = mc_len - MC_CNT_W'(1);
          end else begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {MC_CNT_W{1'b0}};
          end
        end
        ST_MC: begin
          if (stall_req_mem) begin
            state_next_s = ST_MC;
            cnt_next_s   = cnt_r;
          end else if (cnt_r == MC_CNT_W'(1)) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {MC_CNT_W{1'b0}};
          end else begin
            state_next_s = ST_MC;
            cnt_next_s   = cnt_r - MC_CNT_W'(1);
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = {MC_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode; everything reads as idle while reset is held
  always_comb begin
    mc_busy_s = 1'b0;
    mc_done_s = 1'b0;
    ex_req_s  = 1'b0;
    flush_s   = 1'b0;
    stall_s   = 6'b000000;
    new_pc_s  = new_pc_r;
    if (reset) begin
      new_pc_s = {ADDR_W{1'b0}};
    end else begin
      mc_busy_s = (state_r == ST_MC);
      mc_done_s = mc_busy_s && (cnt_r == MC_CNT_W'(1)) && !stall_req_mem && !exc_valid;
      ex_req_s  = mc_busy_s && !mc_done_s;
      flush_s   = exc_valid;
      if (exc_valid) begin
        new_pc_s = exc_vector;
      end else begin
        new_pc_s = new_pc_r;
      end
      // Older stages keep moving: only the stages at and before the requester freeze
      if (flush_s) begin
        stall_s = 6'b000000;
      end else if (stall_req_mem) begin
        stall_s = 6'b011111;
      end else if (ex_req_s) begin
        stall_s = 6'b001111;
      end else if (stall_req_id) begin
        stall_s = 6'b000111;
      end else begin
        stall_s = 6'b000000;
      end
    end
  end

  // Redirect target capture, held between exceptions
  always_ff @(posedge clock) begin
    if (reset) begin
      new_pc_r <= {ADDR_W{1'b0}};
    end else if (exc_valid) begin
      new_pc_r <= exc_vector;
    end else begin
      new_pc_r <= new_pc_r;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if ((stall_s != 6'b000000) && (stall_cycles_r != {PERF_W{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + PERF_W'(1);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall        = stall_s;
  assign flush        = flush_s;
  assign new_pc       = new_pc_s;
  assign mc_busy      = mc_busy_s;
  assign mc_done      = mc_done_s;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;

  logic        clock;
  logic        reset;
  logic        stall_req_id;
  logic        stall_req_mem;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic [31:0] stall_cycles;

  pipeline_ctrl #(.ADDR_W(32), .MC_CNT_W(6), .PERF_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall_req_id (stall_req_id),
    .stall_req_mem(stall_req_mem),
    .mc_start     (mc_start),
    .mc_len       (mc_len),
    .exc_valid    (exc_valid),
    .exc_vector   (exc_vector),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        id;
    logic        mem;
    logic        start;
    logic [5:0]  len;
    logic        exc;
    logic [31:0] vec;
    logic        frc;
    logic        chk;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_idx  = 0;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  function automatic vec_t v(input logic rst, input logic id, input logic mem, input logic start,
                             input logic [5:0] len, input logic exc, input logic [31:0] vec,
                             input logic frc, input logic chk, input logic [5:0] es,
                             input logic ef, input logic [31:0] ep, input logic eb,
                             input logic ed, input logic [31:0] esc);
    vec_t r;
    r.rst = rst; r.id = id; r.mem = mem; r.start = start; r.len = len; r.exc = exc;
    r.vec = vec; r.frc = frc; r.chk = chk; r.e_stall = es; r.e_flush = ef; r.e_pc = ep;
    r.e_busy = eb; r.e_done = ed; r.e_sc = esc;
    return r;
  endfunction

  // Monitor: compare each queued expectation against the settled outputs
  always @(negedge clock) begin
    if (expq.size() > 0) begin
      vec_t e;
      e = expq.pop_front();
      if (e.chk) begin
        n_vec++;
        if (stall !== e.e_stall) begin
          n_miss++; $display("FAIL v%0d stall got %06b want %06b", n_idx, stall, e.e_stall);
        end
        if (flush !== e.e_flush) begin
          n_miss++; $display("FAIL v%0d flush got %0b want %0b", n_idx, flush, e.e_flush);
        end
        if (new_pc !== e.e_pc) begin
          n_miss++; $display("FAIL v%0d new_pc got %08h want %08h", n_idx, new_pc, e.e_pc);
        end
        if (mc_busy !== e.e_busy) begin
          n_miss++; $display("FAIL v%0d mc_busy got %0b want %0b", n_idx, mc_busy, e.e_busy);
        end
        if (mc_done !== e.e_done) begin
          n_miss++; $display("FAIL v%0d mc_done got %0b want %0b", n_idx, mc_done, e.e_done);
        end
        if (stall_cycles !== e.e_sc) begin
          n_miss++; $display("FAIL v%0d stall_cycles got %08h want %08h", n_idx, stall_cycles, e.e_sc);
        end
      end
      n_idx++;
    end
  end

  initial begin
    reset = 1'b1; stall_req_id = 1'b1; stall_req_mem = 1'b1; mc_start = 1'b1;
    mc_len = 6'd4; exc_valid = 1'b1; exc_vector = 32'h0000_DEAD;

    //                rst id mem st len   exc vec           frc chk stall   fl pc            bsy dn sc
    vecs.push_back(v(1'b1,1'b1,1'b1,1'b1,6'd4, 1'b1,32'h0000_DEAD,1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd0));
    vecs.push_back(v(1'b1,1'b1,1'b1,1'b1,6'd4, 1'b1,32'h0000_DEAD,1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd0));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd0));
    // load-use
    vecs.push_back(v(1'b0,1'b1,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h07,1'b0,32'h0,1'b0,1'b0,32'd0));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd1));
    // divide, length 4
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd4, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd1));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd1));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd2));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b1,1'b1,32'd3));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd3));
    // length 1 and 0 are single-cycle
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd1, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd3));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd3));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd3));
    // divide with a MEM wait on the second MC cycle; mc_start mid-op is ignored
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd4, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd3));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd3));
    vecs.push_back(v(1'b0,1'b0,1'b1,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h1F,1'b0,32'h0,1'b1,1'b0,32'd4));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd8, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd5));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b1,1'b1,32'd6));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd6));
    // exception on the third MC cycle of a length-10 op
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd10,1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd6));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd6));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h0,1'b1,1'b0,32'd7));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b1,32'h0000_0020,1'b0,1'b1,6'h00,1'b1,32'h20,1'b1,1'b0,32'd8));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h20,1'b0,1'b0,32'd8));
    // exception with mc_start: start discarded
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd4, 1'b1,32'h0000_0040,1'b0,1'b1,6'h00,1'b1,32'h40,1'b0,1'b0,32'd8));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h40,1'b0,1'b0,32'd8));
    // MEM stall alone
    vecs.push_back(v(1'b0,1'b0,1'b1,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h1F,1'b0,32'h40,1'b0,1'b0,32'd8));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h40,1'b0,1'b0,32'd9));
    // reset mid-op
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b1,6'd6, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h40,1'b0,1'b0,32'd9));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h0F,1'b0,32'h40,1'b1,1'b0,32'd9));
    vecs.push_back(v(1'b1,1'b0,1'b1,1'b1,6'd5, 1'b0,32'h0,        1'b0,1'b0,6'h00,1'b0,32'h0,1'b0,1'b0,32'd0));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,32'd0));
    // saturation from a forced all-ones count
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b1,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,ONES));
    vecs.push_back(v(1'b0,1'b1,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h07,1'b0,32'h0,1'b0,1'b0,ONES));
    vecs.push_back(v(1'b0,1'b1,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h07,1'b0,32'h0,1'b0,1'b0,ONES));
    vecs.push_back(v(1'b0,1'b1,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h07,1'b0,32'h0,1'b0,1'b0,ONES));
    vecs.push_back(v(1'b0,1'b0,1'b0,1'b0,6'd0, 1'b0,32'h0,        1'b0,1'b1,6'h00,1'b0,32'h0,1'b0,1'b0,ONES));

    begin
      logic forced;
      forced = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
        @(posedge clock);
        #1;
        if (vecs[i].frc) begin
          force dut.stall_cycles_r = ONES;
          forced = 1'b1;
        end else if (forced) begin
          release dut.stall_cycles_r;
          forced = 1'b0;
        end
        reset         = vecs[i].rst;
        stall_req_id  = vecs[i].id;
        stall_req_mem = vecs[i].mem;
        mc_start      = vecs[i].start;
        mc_len        = vecs[i].len;
        exc_valid     = vecs[i].exc;
        exc_vector    = vecs[i].vec;
        expq.push_back(vecs[i]);
      end
    end

    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      @(posedge clock);
    end
    if (expq.size() > 0) begin
      n_miss++;
      $display("FAIL drain queue left %0d want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
